// File: rtl/fm_dist_scheduler.sv
// fm_dist_scheduler: clamps distance samples and slews them toward the FM DAC on PWM-period boundaries, gating the DAC enable
module fm_dist_scheduler #(
   parameter int WIDTH      = 13,
   parameter int MAX_DIST   = 2000,
   parameter int STEP_MAX   = 16,
   parameter int UPDATE_DIV = 4,
   parameter int TIMEOUT    = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] dist_in,
   input  logic             dist_valid,
   output logic             dist_ready,
   input  logic             pwm_zero,
   output logic [WIDTH-1:0] distance_out,
   output logic             dac_enable,
   output logic [1:0]       state_out,
   output logic             stale
);
   localparam int DW = $clog2(UPDATE_DIV + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE = 2'b00, ACQUIRE = 2'b01, TRACK = 2'b10, STALE = 2'b11} state_t;
   state_t state, next_state;
   logic [WIDTH-1:0] target, clamped, diff, step_size, slewed;
   logic [DW-1:0] div;
   logic [TW-1:0] tcnt;
   logic accept, track_pulse, tick, timeout, up;
   assign dist_ready  = state != IDLE;
   assign stale       = state == STALE;
   assign state_out   = state;
   assign accept      = dist_valid & dist_ready;
   assign clamped     = dist_in > WIDTH'(MAX_DIST) ? WIDTH'(MAX_DIST) : dist_in;
   assign track_pulse = state == TRACK && pwm_zero;
   assign tick        = track_pulse && div == DW'(UPDATE_DIV - 1);
   assign timeout     = track_pulse && !accept && tcnt == TW'(TIMEOUT - 1);
   // Step of at most STEP_MAX toward target; since target is already clamped the result stays in range
   always_comb begin
      up        = target > distance_out;
      diff      = up ? target - distance_out : distance_out - target;
      step_size = diff > WIDTH'(STEP_MAX) ? WIDTH'(STEP_MAX) : diff;
      slewed    = up ? distance_out + step_size : distance_out - step_size;
   end
   // Next-state logic; stop overrides every other request, including start in IDLE
   always_comb begin
      next_state = state;
      if (stop)
         next_state = IDLE;
      else
         case (state)
            IDLE:    next_state = start ? ACQUIRE : IDLE;
            ACQUIRE: next_state = accept ? TRACK : ACQUIRE;
            TRACK:   next_state = timeout ? STALE : TRACK;
            STALE:   next_state = accept ? TRACK : STALE;
            default: next_state = IDLE;
         endcase
   end
   // State, outputs and counters; a tick coinciding with an accept still slews toward the old target
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         distance_out <= '0;
         target       <= '0;
         dac_enable   <= 1'b0;
         div          <= '0;
         tcnt         <= '0;
      end else begin
         state      <= next_state;
         dac_enable <= next_state == TRACK;
         if (accept)
            target <= clamped;
         if (!stop && accept && (state == ACQUIRE || state == STALE))
            distance_out <= clamped;
         else if (!stop && tick)
            distance_out <= slewed;
         div  <= stop ? '0 : tick ? '0 : track_pulse ? div + 1'b1 : div;
         tcnt <= (stop || accept) ? '0 :
                 (track_pulse && tcnt != TW'(TIMEOUT - 1)) ? tcnt + 1'b1 : tcnt;
      end
   end
endmodule
